// File: rtl/capi_get_xfer_trk_pkg.sv
// Shared constants for the CAPI get-transfer tracker: FSM encoding and beat width.
package capi_get_pkg;

   localparam int BEAT_W   = 130;
   localparam int FIFO_W   = BEAT_W + 4 + 1;
   localparam int ST_COUNT = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Odd parity, matching the capi_parity_gen convention.
   function automatic logic par_odd(input logic [63:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/capi_get_xfer_trk_if.sv
// Beat-in, beat-out and completion channels of the get-transfer tracker.
interface capi_get_xfer_trk_if #(
   parameter int rc_width   = 8,
   parameter int bcnt_width = 24
);
   import capi_get_pkg::*;

   logic                    i_v, i_r, i_e;
   logic [0:BEAT_W-1]       i_d;
   logic [0:3]              i_c;
   logic [0:rc_width-1]     i_rc;
   logic [0:bcnt_width-1]   i_bcnt;
   logic                    o_v, o_r, o_e;
   logic [0:BEAT_W-1]       o_d;
   logic [0:3]              o_c;
   logic                    c_v, c_r, c_perror;
   logic [0:rc_width-1]     c_rc;
   logic [0:bcnt_width-1]   c_bcnt;
   logic [0:11]             c_beats;

   modport slave (
      input  i_v, i_d, i_c, i_e, i_rc, i_bcnt, o_r, c_r,
      output i_r, o_v, o_d, o_c, o_e, c_v, c_rc, c_bcnt, c_beats, c_perror
   );
   modport master (
      output i_v, i_d, i_c, i_e, i_rc, i_bcnt, o_r, c_r,
      input  i_r, o_v, o_d, o_c, o_e, c_v, c_rc, c_bcnt, c_beats, c_perror
   );
endinterface

// File: rtl/capi_get_trk_fifo.sv
// Registered-state FIFO; ready reflects fullness only, so a read never frees a slot the same cycle.
module capi_get_trk_fifo #(
   parameter int width     = 135,
   parameter int depth_lg2 = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wv,
   output logic             o_wr,
   input  logic [width-1:0] i_wd,
   output logic             o_rv,
   input  logic             i_rr,
   output logic [width-1:0] o_rd
);
   localparam int DEPTH = 2 ** depth_lg2;

   logic [width-1:0]   r_mem [0:DEPTH-1];
   logic [depth_lg2:0] r_wp, r_rp;
   logic               w_full, w_empty, w_wen, w_ren;

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[depth_lg2] != r_rp[depth_lg2]) &&
                    (r_wp[depth_lg2-1:0] == r_rp[depth_lg2-1:0]);
   assign o_wr    = ~w_full;
   assign o_rv    = ~w_empty;
   assign w_wen   = i_wv & ~w_full;
   assign w_ren   = i_rr & ~w_empty;
   assign o_rd    = r_mem[r_rp[depth_lg2-1:0]];

   // Pointer update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp <= {(depth_lg2+1){1'b0}};
         r_rp <= {(depth_lg2+1){1'b0}};
      end else begin
         if (w_wen) r_wp <= r_wp + {{depth_lg2{1'b0}}, 1'b1};
         if (w_ren) r_rp <= r_rp + {{depth_lg2{1'b0}}, 1'b1};
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (w_wen) r_mem[r_wp[depth_lg2-1:0]] <= i_wd;
   end
endmodule

// File: rtl/capi_get_xfer_trk.sv
// Tracks one CAPI get transfer: buffers beats, collects rc/bcnt/beat count, issues a completion.
// Optional parity checking is built when CAPI_GET_XFER_PARCHK_EN is defined.
module capi_get_xfer_trk
   import capi_get_pkg::*;
#(
   parameter int rc_width   = 8,
   parameter int bcnt_width = 24,
   parameter int depth_lg2  = 3
) (
   input  logic                clk,
   input  logic                reset,
   capi_get_xfer_trk_if.slave  bus,
   output logic                o_perror
);
   state_t                r_state, w_next;
   logic                  r_rdy, r_eout, w_acc, w_to_idle, w_fifo_wr, w_fifo_rv, w_oe_done;
   logic [FIFO_W-1:0]     w_fifo_rd;
   logic [11:0]           r_cnt;
   logic [0:rc_width-1]   r_rc;
   logic [0:bcnt_width-1] r_bcnt;

   assign bus.i_r   = r_rdy & w_fifo_wr & (r_state != ST_HOLD);
   assign w_acc     = bus.i_v & bus.i_r;
   assign bus.o_v   = w_fifo_rv;
   assign {bus.o_d, bus.o_c, bus.o_e} = w_fifo_rd;
   assign w_oe_done = bus.o_v & bus.o_r & bus.o_e;
   assign bus.c_v   = (r_state == ST_HOLD) & r_eout;
   assign bus.c_rc    = r_rc;
   assign bus.c_bcnt  = r_bcnt;
   assign bus.c_beats = r_cnt;

   capi_get_trk_fifo #(.width(FIFO_W), .depth_lg2(depth_lg2)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .i_wv  (w_acc),
      .o_wr  (w_fifo_wr),
      .i_wd  ({bus.i_d, bus.i_c, bus.i_e}),
      .o_rv  (w_fifo_rv),
      .i_rr  (bus.o_r),
      .o_rd  (w_fifo_rd)
   );

   // Next-state decode
   always_comb begin
      w_next    = r_state;
      w_to_idle = 1'b0;
      case (r_state)
         ST_IDLE: if (w_acc) w_next = bus.i_e ? ST_HOLD : ST_XFER; else w_next = ST_IDLE;
         ST_XFER: if (w_acc && bus.i_e) w_next = ST_HOLD; else w_next = ST_XFER;
         ST_HOLD: begin
            if (bus.c_v && bus.c_r) begin
               w_next    = ST_IDLE;
               w_to_idle = 1'b1;
            end else begin
               w_next    = ST_HOLD;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State and completion-record registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_rdy   <= 1'b0;
         r_eout  <= 1'b0;
         r_cnt   <= 12'd0;
         r_rc    <= {rc_width{1'b0}};
         r_bcnt  <= {bcnt_width{1'b0}};
      end else begin
         r_state <= w_next;
         r_rdy   <= 1'b1;
         if (w_to_idle)      r_eout <= 1'b0;
         else if (w_oe_done) r_eout <= 1'b1;
         if (w_to_idle)                        r_cnt <= 12'd0;
         else if (w_acc && r_cnt != 12'd4095)  r_cnt <= r_cnt + 12'd1;
         // Only the first nonzero return code of a transfer is kept.
         if (w_to_idle)                                r_rc <= {rc_width{1'b0}};
         else if (w_acc && r_rc == {rc_width{1'b0}})   r_rc <= bus.i_rc;
         if (w_acc && bus.i_e) r_bcnt <= bus.i_bcnt;
      end
   end

`ifdef CAPI_GET_XFER_PARCHK_EN
   logic w_perr, r_cperr, r_operr;

   assign w_perr = w_acc & ((par_odd(bus.i_d[0:63])   != bus.i_d[128]) |
                            (par_odd(bus.i_d[64:127]) != bus.i_d[129]));
   assign bus.c_perror = r_cperr;
   assign o_perror     = r_operr;

   // Per-transfer and sticky parity error flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cperr <= 1'b0;
         r_operr <= 1'b0;
      end else begin
         if (w_to_idle)   r_cperr <= 1'b0;
         else if (w_perr) r_cperr <= 1'b1;
         if (w_perr)      r_operr <= 1'b1;
      end
   end
`else
   assign bus.c_perror = 1'b0;
   assign o_perror     = 1'b0;
`endif
endmodule

// File: tb/tb_capi_get_xfer_trk.sv
// Directed bench for capi_get_xfer_trk; parity scenario runs only with CAPI_GET_XFER_PARCHK_EN.
module tb_capi_get_xfer_trk;
   logic clk, reset, o_perror;
   int   vectors = 0;
   int   miscompares = 0;

   capi_get_xfer_trk_if #(.rc_width(8), .bcnt_width(24)) bus ();

   capi_get_xfer_trk #(.rc_width(8), .bcnt_width(24), .depth_lg2(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .o_perror (o_perror)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [134:0] obs, input logic [134:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [0:129] mk(input int n);
      logic [0:129] d;
      d[0:63]   = {32'hDEAD0000 + n[31:0], n[31:0]};
      d[64:127] = {~n[31:0], 32'hC0DE0000 + n[31:0]};
      d[128]    = ~(^d[0:63]);
      d[129]    = ~(^d[64:127]);
      return d;
   endfunction

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic push(input logic [0:129] d, input logic e, input logic [7:0] rc, input logic [23:0] bcnt);
      int n = 0;
      bus.i_v = 1'b1; bus.i_d = d; bus.i_c = 4'h3; bus.i_e = e; bus.i_rc = rc; bus.i_bcnt = bcnt;
      while (!bus.i_r && n < 50) begin @(negedge clk); n++; end
      chk("push_rdy", bus.i_r, 1'b1);
      @(posedge clk); @(negedge clk);
      bus.i_v = 1'b0;
   endtask

   task automatic finish_xfer(input logic [11:0] beats, input logic [7:0] rc, input logic [23:0] bcnt,
                              input logic cperr, input logic operr);
      int n = 0;
      while (!bus.c_v && n < 50) begin @(negedge clk); n++; end
      chk("c_v", bus.c_v, 1'b1);
      chk("c_beats", bus.c_beats, beats);
      chk("c_rc", bus.c_rc, rc);
      chk("c_bcnt", bus.c_bcnt, bcnt);
      chk("c_perror", bus.c_perror, cperr);
      chk("o_perror", o_perror, operr);
      @(posedge clk); @(negedge clk);
      chk("c_v_done", bus.c_v, 1'b0);
      chk("i_r_idle", bus.i_r, 1'b1);
   endtask

   initial begin
      logic [0:129] d;
      logic perr_exp;
`ifdef CAPI_GET_XFER_PARCHK_EN
      perr_exp = 1'b1;
`else
      perr_exp = 1'b0;
`endif
      reset = 1'b1;
      bus.i_v = 1'b0; bus.i_d = '0; bus.i_c = 4'h0; bus.i_e = 1'b0; bus.i_rc = 8'h00; bus.i_bcnt = 24'h0;
      bus.o_r = 1'b1; bus.c_r = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("rst_i_r", bus.i_r, 1'b0);
      chk("rst_o_v", bus.o_v, 1'b0);
      chk("rst_c_v", bus.c_v, 1'b0);
      chk("rst_beats", bus.c_beats, 12'd0);
      chk("rst_rc", bus.c_rc, 8'h00);
      chk("rst_bcnt", bus.c_bcnt, 24'd0);
      chk("rst_operr", o_perror, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_i_r", bus.i_r, 1'b1);

      // 3-beat transfer with o_r=1: one-cycle FIFO latency
      bus.i_v = 1'b1; bus.i_d = mk(0); bus.i_c = 4'h1; bus.i_e = 1'b0; bus.i_rc = 8'h00; bus.i_bcnt = 24'd16;
      chk("t1_o_v_pre", bus.o_v, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("t1_o_v1", bus.o_v, 1'b1);
      chk("t1_o_d1", bus.o_d, mk(0));
      bus.i_d = mk(1); bus.i_bcnt = 24'd32;
      @(posedge clk); @(negedge clk);
      chk("t1_o_d2", bus.o_d, mk(1));
      bus.i_d = mk(2); bus.i_e = 1'b1; bus.i_bcnt = 24'd48;
      @(posedge clk); @(negedge clk);
      bus.i_v = 1'b0;
      chk("t1_o_d3", bus.o_d, mk(2));
      chk("t1_o_e3", bus.o_e, 1'b1);
      chk("t1_c_v_early", bus.c_v, 1'b0);
      chk("t1_i_r_hold", bus.i_r, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("t1_o_v_empty", bus.o_v, 1'b0);
      finish_xfer(12'd3, 8'h00, 24'd48, 1'b0, 1'b0);

      // Fill FIFO with o_r=0, then free one slot
      bus.o_r = 1'b0;
      for (int k = 0; k < 8; k++) push(mk(k + 100), 1'b0, 8'h00, 24'd0);
      chk("t2_full_i_r", bus.i_r, 1'b0);
      chk("t2_head", bus.o_d, mk(100));
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("t2_head_stable", bus.o_d, mk(100));
      bus.o_r = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.o_r = 1'b0;
      chk("t2_i_r_freed", bus.i_r, 1'b1);
      bus.o_r = 1'b1;
      for (int k = 1; k < 8; k++) begin
         chk("t2_order", bus.o_d, mk(k + 100));
         @(posedge clk); @(negedge clk);
      end
      chk("t2_drained", bus.o_v, 1'b0);
      push(mk(108), 1'b1, 8'h00, 24'd100);
      finish_xfer(12'd9, 8'h00, 24'd100, 1'b0, 1'b0);

      // First nonzero rc wins; next transfer starts clean (single-beat IDLE->HOLD)
      push(mk(10), 1'b0, 8'h00, 24'd12);
      push(mk(11), 1'b0, 8'h05, 24'd24);
      chk("t3_fwd", bus.o_d, mk(11));
      push(mk(12), 1'b1, 8'h09, 24'd36);
      finish_xfer(12'd3, 8'h05, 24'd36, 1'b0, 1'b0);
      push(mk(13), 1'b1, 8'h00, 24'd12);
      finish_xfer(12'd1, 8'h00, 24'd12, 1'b0, 1'b0);

      // Completion back-pressure: record held, input blocked
      bus.c_r = 1'b0;
      push(mk(20), 1'b0, 8'h03, 24'd4);
      push(mk(21), 1'b1, 8'h00, 24'd7);
      for (int n = 0; n < 50 && !bus.c_v; n++) @(negedge clk);
      bus.i_v = 1'b1; bus.i_d = mk(22); bus.i_e = 1'b1; bus.i_rc = 8'h00; bus.i_bcnt = 24'd5;
      for (int k = 0; k < 10; k++) begin
         chk("t4_c_v", bus.c_v, 1'b1);
         chk("t4_beats", bus.c_beats, 12'd2);
         chk("t4_rc", bus.c_rc, 8'h03);
         chk("t4_bcnt", bus.c_bcnt, 24'd7);
         chk("t4_i_r", bus.i_r, 1'b0);
         @(posedge clk); @(negedge clk);
      end
      bus.c_r = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("t4_c_v_off", bus.c_v, 1'b0);
      chk("t4_i_r_on", bus.i_r, 1'b1);
      @(posedge clk); @(negedge clk);
      bus.i_v = 1'b0;
      finish_xfer(12'd1, 8'h00, 24'd5, 1'b0, 1'b0);

      // Reset mid-transfer with 4 beats buffered
      bus.o_r = 1'b0;
      for (int k = 0; k < 4; k++) push(mk(k + 30), 1'b0, 8'h07, 24'd0);
      chk("t5_o_v_pre", bus.o_v, 1'b1);
      reset = 1'b1;
      #1;
      chk("t5_o_v_rst", bus.o_v, 1'b0);
      chk("t5_c_v_rst", bus.c_v, 1'b0);
      chk("t5_i_r_rst", bus.i_r, 1'b0);
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("t5_empty", bus.o_v, 1'b0);
      chk("t5_i_r", bus.i_r, 1'b1);
      chk("t5_beats0", bus.c_beats, 12'd0);
      bus.o_r = 1'b1;
      push(mk(40), 1'b0, 8'h00, 24'd1);
      push(mk(41), 1'b1, 8'h00, 24'd2);
      finish_xfer(12'd2, 8'h00, 24'd2, 1'b0, 1'b0);

      // Parity error on bit 70 of the first beat; sticky flag survives later transfers
      d = mk(50);
      d[70] = ~d[70];
      push(d, 1'b0, 8'h00, 24'd0);
      chk("t6_o_perror_next", o_perror, perr_exp);
      push(mk(51), 1'b1, 8'h00, 24'd9);
      finish_xfer(12'd2, 8'h00, 24'd9, perr_exp, perr_exp);
      push(mk(52), 1'b1, 8'h00, 24'd3);
      finish_xfer(12'd1, 8'h00, 24'd3, 1'b0, perr_exp);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      chk("t6_operr_cleared", o_perror, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/capi_get_xfer_trk.md
CAPI_GET_XFER_TRK -- requirements
Module: capi_get_xfer_trk

Interface
REQ-001 SHALL have parameter rc_width, default 8: width of return-code field.
REQ-002 SHALL have parameter bcnt_width, default 24: width of byte-count field.
REQ-003 SHALL have parameter depth_lg2, default 3: log2 of data FIFO depth (8 beats).
REQ-004 SHALL have port clk  in  1: single clock, all state rising-edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-006 SHALL have ports i_v in 1 / i_r out 1: valid/ready for the aligned input beat stream.
REQ-007 SHALL have ports i_d in [0:129], i_c in [0:3], i_e in 1, i_rc in [0:rc_width-1], i_bcnt in [0:bcnt_width-1]: aligned data plus two parity bits, end count, end flag, return code, running byte count.
REQ-008 SHALL have ports o_v out 1 / o_r in 1, o_d out [0:129], o_c out [0:3], o_e out 1: buffered data stream to the consumer.
REQ-009 SHALL have ports c_v out 1 / c_r in 1, c_rc out [0:rc_width-1], c_bcnt out [0:bcnt_width-1], c_beats out [0:11], c_perror out 1: one completion record per transfer.
REQ-010 SHALL have port o_perror out 1: sticky parity-error flag, registered.

Function
REQ-011 Input beat accepted when i_v & i_r; data output beat transferred when o_v & o_r; completion taken when c_v & c_r.
REQ-012 Accepted beats SHALL be written into a FIFO of 2^depth_lg2 entries holding {i_d,i_c,i_e}; o_v SHALL first assert the cycle after acceptance (1-cycle latency, no bypass).
REQ-013 i_r SHALL be low when FIFO full or state is HOLD; a simultaneous write and read on a full FIFO SHALL NOT be accepted (i_r depends on registered state only).
REQ-014 FSM states: IDLE (no beat of current transfer accepted), XFER (beats accepted, no i_e yet), HOLD (i_e beat accepted, completion pending).
REQ-015 IDLE->XFER on an accepted beat with i_e=0; IDLE->HOLD or XFER->HOLD on an accepted beat with i_e=1; HOLD->IDLE on the cycle c_v & c_r.
REQ-016 Beat counter SHALL clear on entry to IDLE, increment per accepted beat, saturate at 4095; c_beats = count including the i_e beat.
REQ-017 c_rc SHALL hold the first nonzero i_rc of the transfer, else zero; later nonzero codes SHALL NOT overwrite it.
REQ-018 c_bcnt SHALL capture i_bcnt of the i_e beat.
REQ-019 c_v SHALL assert only in HOLD and only after the i_e beat has left o_d (o_v & o_r & o_e), i.e. no earlier than the cycle after that transfer; c_v SHALL stay high with stable fields until c_r.
REQ-020 Beats with nonzero i_rc SHALL still be forwarded unchanged.
REQ-021 o_v, c_v low whenever FIFO empty / state not HOLD respectively; o_d/o_c/o_e SHALL be stable while o_v & ~o_r.

Reset
REQ-022 On reset assertion (any time, incl. mid-transfer): state IDLE, FIFO empty, counter/c_rc/c_bcnt/c_perror/o_perror zero, i_r low, o_v low, c_v low; in-flight beats discarded.
REQ-023 i_r SHALL assert the first cycle after reset deasserts.

Configuration
REQ-024 With CAPI_GET_XFER_PARCHK_EN defined, each accepted beat SHALL check i_d[0:63] against i_d[128] and i_d[64:127] against i_d[129] (parity as generated by capi_parity_gen); a mismatch SHALL set c_perror for the current transfer and set o_perror (sticky until reset) on the next cycle.
REQ-025 Without CAPI_GET_XFER_PARCHK_EN, no checker logic SHALL exist; c_perror and o_perror SHALL be constant 0; data still passes parity bits through.

Structure
REQ-026 FSM state encoding, FSM state count and the 130-bit beat width SHALL be constants in shared package capi_get_pkg.
REQ-027 Data FIFO SHALL be a separate sub-module capi_get_trk_fifo (parameters width, depth_lg2; valid/ready both sides).

Verification
REQ-028 3-beat transfer, i_rc=0, i_bcnt=48 on end, o_r=1 -> o_v cycles 1..3 after accept, c_v one cycle after o_e beat leaves, c_beats=3, c_bcnt=48, c_rc=0.
REQ-029 o_r=0, push 8 beats no i_e -> i_r low after 8th accept; o_r=1 one cycle -> i_r high next cycle, order preserved.
REQ-030 Beat 2 i_rc=0x05, beat 3 i_rc=0x09 with i_e -> c_rc=0x05; next transfer c_rc=0.
REQ-031 c_r held low 10 cycles after completion -> i_r low throughout HOLD, c_v/fields stable; c_r=1 -> IDLE, next transfer accepted.
REQ-032 With CAPI_GET_XFER_PARCHK_EN: flip i_d[70] on beat 1 -> c_perror=1, o_perror=1 next cycle and remains 1 across later transfers until reset.
REQ-033 Assert reset during XFER with 4 beats buffered -> o_v, c_v, i_r low immediately; after release FIFO empty, counter 0, fresh transfer completes with c_beats correct.
